// File: rtl/sc_final_add_pkg.sv
// sc_final_add_pkg
//   Shared constants and types for the final carry-propagate adder / MAC
//   stage that follows the approximate 4-2 compressor tree.
//   W_DEF     : default sum/carry vector width
//   ACC_W_DEF : default accumulator / result width
//   CNT_W     : width of the per-group product counter
//   sc_pair_t : {s, c} bundle as produced by the last compressor row
package sc_final_add_pkg;

  localparam int W_DEF     = 16;
  localparam int ACC_W_DEF = 24;
  localparam int CNT_W     = 8;

  typedef struct packed {
    logic [W_DEF-1:0] s;  // weight 2^i
    logic [W_DEF-1:0] c;  // weight 2^(i+1)
  } sc_pair_t;

endpackage

// File: rtl/sc_final_add_half_cpa.sv
// half_cpa
//   Parameterised N-bit ripple adder with carry-in and carry-out, used for
//   the low and high halves of the final carry-propagate addition.
//   a, b : N-bit operands
//   ci   : carry in
//   sum  : N-bit sum
//   co   : carry out
module half_cpa #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] sum,
  output logic         co
);

  logic [N:0] tot;

  assign tot = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
  assign sum = tot[N-1:0];
  assign co  = tot[N];

endmodule

// File: rtl/sc_final_add.sv
// sc_final_add
//   Resolves the compressor-tree sum/carry pair into a binary product over
//   two pipeline halves, accumulates products per group (closed by in_last)
//   and presents the saturated group sum through a valid/ready handshake.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : input handshake; in_ready depends only on the
//                         output handshake state
//   s_vec, c_vec        : sum vector (2^i) and carry vector (2^(i+1))
//   in_last             : this product closes the current group
//   out_valid/out_ready : output handshake
//   out_data            : saturated group sum
//   out_cnt             : products in the group, saturating at 255
//   out_sat             : group sum saturated
module sc_final_add
  import sc_final_add_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     s_vec,
  input  logic [W-1:0]     c_vec,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_sat
);

  localparam int H = W / 2;

  // Single advance enable: the whole pipe freezes while a result waits.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // ---------------- stage 1: low half ----------------
  logic [H-1:0] lo_sum;
  logic         lo_co;

  half_cpa #(.N(H)) u_lo (
    .a  (s_vec[H-1:0]),
    .b  ({c_vec[H-2:0], 1'b0}),
    .ci (1'b0),
    .sum(lo_sum),
    .co (lo_co)
  );

  logic         v1;
  logic         last1;
  logic [H-1:0] lo1;
  logic         cy1;
  logic [H-1:0] s_hi1;
  logic [H:0]   c_hi1;

  // ---------------- stage 2: high half ----------------
  // c_vec[W-1:H-1] carries one extra bit of weight, so the high adder is
  // H+1 bits wide and its carry-out gives the top product bit.
  logic [H:0] hi_sum;
  logic       hi_co;

  half_cpa #(.N(H+1)) u_hi (
    .a  ({1'b0, s_hi1}),
    .b  (c_hi1),
    .ci (cy1),
    .sum(hi_sum),
    .co (hi_co)
  );

  logic         v2;
  logic         last2;
  logic [W+1:0] p2;

  // ---------------- stage 3: accumulate ----------------
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             sat;

  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] acc_upd;
  logic [CNT_W-1:0] cnt_upd;
  logic             sat_upd;

  always_comb begin
    sum_ext = {1'b0, acc} + (ACC_W+1)'(p2);
    acc_upd = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
    sat_upd = sat | sum_ext[ACC_W];
    cnt_upd = (cnt == '1) ? cnt : cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      last1     <= 1'b0;
      lo1       <= '0;
      cy1       <= 1'b0;
      s_hi1     <= '0;
      c_hi1     <= '0;
      v2        <= 1'b0;
      last2     <= 1'b0;
      p2        <= '0;
      acc       <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_cnt   <= '0;
      out_sat   <= 1'b0;
    end else if (en) begin
      v1        <= in_valid;
      last1     <= in_last;
      lo1       <= lo_sum;
      cy1       <= lo_co;
      s_hi1     <= s_vec[W-1:H];
      c_hi1     <= c_vec[W-1:H-1];

      v2        <= v1;
      last2     <= last1;
      p2        <= {hi_co, hi_sum, lo1};

      // With en high the held result is either consumed or absent, so the
      // new valid is simply whether a group closes on this edge.
      out_valid <= v2 && last2;
      if (v2) begin
        if (last2) begin
          out_data <= acc_upd;
          out_cnt  <= cnt_upd;
          out_sat  <= sat_upd;
          acc      <= '0;
          cnt      <= '0;
          sat      <= 1'b0;
        end else begin
          acc      <= acc_upd;
          cnt      <= cnt_upd;
          sat      <= sat_upd;
        end
      end
    end
  end

endmodule

// File: tb/tb_sc_final_add.sv
// tb_sc_final_add
//   Directed self-checking bench for sc_final_add (W=16, ACC_W=24).
//   Inputs change and outputs are sampled on the falling clock edge.
module tb_sc_final_add;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] s_vec;
  logic [15:0] c_vec;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic [7:0]  out_cnt;
  logic        out_sat;

  int unsigned compared = 0;
  int unsigned mismatched = 0;

  sc_final_add #(.W(16), .ACC_W(24)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .s_vec    (s_vec),
    .c_vec    (c_vec),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_cnt  (out_cnt),
    .out_sat  (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
      else begin
        mismatched++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [23:0] d,
                           input logic [7:0] n, input logic s);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".data"},  32'(out_data),  32'(d));
    check({tag, ".cnt"},   32'(out_cnt),   32'(n));
    check({tag, ".sat"},   32'(out_sat),   32'(s));
  endtask

  // Present one beat at a falling edge and hold it until a rising edge
  // accepts it; returns on the falling edge after acceptance.
  task automatic drive(input logic [15:0] s, input logic [15:0] c, input logic last);
    int unsigned n;
    logic took;
    n = 0;
    took = 1'b0;
    in_valid = 1'b1;
    s_vec    = s;
    c_vec    = c;
    in_last  = last;
    do begin
      #1;
      took = in_ready;
      @(negedge clk);
      n++;
    end while (!took && n < 50);
    if (!took) check("drive_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    s_vec     = '0;
    c_vec     = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    #3;
    check_out("reset", 1'b0, 24'h0, 8'd0, 1'b0);
    check("reset.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // One-beat group: P = 0x00FF + 0x0002 = 0x0101, visible after edge k+2.
    drive(16'h00FF, 16'h0001, 1'b1);
    @(negedge clk);
    check("lat.k1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_out("single", 1'b1, 24'h000101, 8'd1, 1'b0);
    @(negedge clk);
    check("single.drain", 32'(out_valid), 32'd0);

    // Low-half carry crossing: 0x00FF + 0x0100 = 0x01FF.
    drive(16'h00FF, 16'h0080, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check_out("lowcarry", 1'b1, 24'h0001FF, 8'd1, 1'b0);

    // Two beats: 0x01FF + 0x2FFFD = 0x301FC.
    drive(16'h00FF, 16'h0080, 1'b0);
    drive(16'hFFFF, 16'hFFFF, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check_out("two_beat", 1'b1, 24'h0301FC, 8'd2, 1'b0);

    // 200 x 0x2FFFD = 39,321,000 > 2^24-1 -> clamp.
    for (int i = 0; i < 199; i++) drive(16'hFFFF, 16'hFFFF, 1'b0);
    drive(16'hFFFF, 16'hFFFF, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check_out("sat", 1'b1, 24'hFFFFFF, 8'd200, 1'b0 | 1'b1);

    // Following group restarts from zero with sat clear.
    drive(16'h0001, 16'h0000, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check_out("after_sat", 1'b1, 24'h000001, 8'd1, 1'b0);
    @(negedge clk);

    // Back-pressure: A=0x10 (1 beat), B=0x20+0x30 (2 beats), C=0x40 (1 beat).
    drive(16'h0010, 16'h0000, 1'b1);
    drive(16'h0020, 16'h0000, 1'b0);
    drive(16'h0030, 16'h0000, 1'b1);
    check_out("bp.A", 1'b1, 24'h000010, 8'd1, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    s_vec     = 16'h0040;
    c_vec     = 16'h0000;
    in_last   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp.in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      check("bp.hold_valid", 32'(out_valid), 32'd1);
      check("bp.hold_data",  32'(out_data),  32'h10);
    end
    out_ready = 1'b1;
    #1;
    check("bp.release_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp.gap", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_out("bp.B", 1'b1, 24'h000050, 8'd2, 1'b0);
    @(negedge clk);
    check_out("bp.C", 1'b1, 24'h000040, 8'd1, 1'b0);
    @(negedge clk);
    check("bp.drain", 32'(out_valid), 32'd0);

    // Simultaneous drain and reload: back-to-back one-beat groups.
    drive(16'h0005, 16'h0000, 1'b1);
    drive(16'h0007, 16'h0000, 1'b1);
    @(negedge clk);
    check_out("reload.D", 1'b1, 24'h000005, 8'd1, 1'b0);
    @(negedge clk);
    check_out("reload.E", 1'b1, 24'h000007, 8'd1, 1'b0);
    @(negedge clk);
    check("reload.drain", 32'(out_valid), 32'd0);

    // Reset mid-group: result 9 held on out_data, three beats in flight.
    drive(16'h0009, 16'h0000, 1'b1);
    drive(16'h0001, 16'h0000, 1'b0);
    drive(16'h0001, 16'h0000, 1'b0);
    drive(16'h0001, 16'h0000, 1'b0);
    check("rst.pre_data", 32'(out_data), 32'h9);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("rst.async", 1'b0, 24'h0, 8'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(16'h0001, 16'h0000, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check_out("rst.after", 1'b1, 24'h000001, 8'd1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sc_final_add.md
# sc_final_add

Pipelined final carry-propagate adder and accumulator that sits directly downstream of the approximate 4-2 compressor tree. It consumes the sum/carry vector pair left by the last compressor row and resolves it into a binary product in two pipeline halves. It then accumulates products over a group delimited by `in_last` and emits the saturated group sum with a valid/ready handshake. It turns the compressor-based multiplier array into a registered, back-pressurable MAC datapath.

## Interface
- `W`, 16, width of the sum and carry vectors from the compressor tree; must be even and ≥4
- `ACC_W`, 24, accumulator and result width; must be ≥ W+2
- `clk` input 1 — single clock, rising edge
- `rst_n` input 1 — asynchronous, active-low reset
- `in_valid` input 1 — `s_vec`/`c_vec`/`in_last` valid
- `in_ready` output 1 — block accepts input this cycle
- `s_vec` input W — sum vector, weight 2^i per bit i
- `c_vec` input W — carry vector, weight 2^(i+1) per bit i
- `in_last` input 1 — this product closes the current accumulation group
- `out_valid` output 1 — result holding
- `out_ready` input 1 — downstream accepts result
- `out_data` output ACC_W — saturated group sum
- `out_cnt` output 8 — number of products in group, saturating at 255
- `out_sat` output 1 — group sum saturated

## Operation
- Product P = s_vec + (c_vec << 1), exact; range 0 .. 3·(2^W−1), held in W+2 bits.
- Stage 1 (low half, H = W/2): L = s_vec[H-1:0] + {c_vec[H-2:0],1'b0} as H+1 bits; register L[H-1:0] and carry L[H]; register s_vec[W-1:H], c_vec[W-1:H-1], in_last, valid.
- Stage 2 (high half): U = s_vec[W-1:H] + c_vec[W-1:H-1] + carry as H+2 bits; register P = {U, L[H-1:0]}, last, valid.
- Stage 3 (accumulate): on valid stage-2 data, sum = acc + P computed in ACC_W+1 bits.
  - Overflow sets the sticky sat flag and clamps to 2^ACC_W−1.
  - cnt increments, saturating at 255.
  - If last: load `out_data`, `out_cnt`, `out_sat` from the updated values, set `out_valid`, clear acc/cnt/sat to 0.
  - Else: acc/cnt/sat take the updated values.
- Global advance enable `en = !out_valid || out_ready`. All three stages and the accumulator move only when `en` = 1. `in_ready = en`, purely combinational from `out_valid`/`out_ready`.
- Output handshake: `out_valid` stays high with `out_data`/`out_cnt`/`out_sat` stable until the cycle where `out_ready` = 1. It clears on that edge unless a new last product reaches stage 3 on the same edge, in which case it reloads with the new group.
- Bubbles (`in_valid` = 0) propagate as invalid stages. They never touch acc or cnt.
- A group of one product (`in_last` on the first beat) is legal: `out_cnt` = 1.
- Reset (any time, including mid-group or with `out_valid` high): all stage valids, acc, cnt and sat go to 0. `out_valid` = 0, `out_data` = 0, `out_cnt` = 0, `out_sat` = 0. In-flight products are discarded.

## Timing
- Throughput: one product per cycle while `en` = 1.
- Latency: a last product accepted at edge k appears on `out_valid`/`out_data` after edge k+2.
- Stall: with `out_valid` = 1 and `out_ready` = 0, every register holds and `in_ready` = 0 in the same cycle. No data is lost or duplicated.
- No combinational path from `in_valid` to `out_*`. The only combinational path to `in_ready` is from `out_ready`.

## Structure
- Shared package: default `W`/`ACC_W` constants, `CNT_W` = 8, and a `sc_pair_t` struct {s, c} matching the compressor-tree output bundle so upstream wiring stays typed.
- One natural sub-module, `half_cpa`: a parameterised H-bit adder with carry-in and carry-out, instantiated for the low and high halves. Everything else stays in the top level.

## Test plan
- W=16, ACC_W=24, single group with `in_last` on beat 1: s=0x00FF, c=0x0001 → P=0x0101; `out_data`=0x000101, `out_cnt`=1, `out_sat`=0, `out_valid` after edge k+2.
- Low-half carry crossing: s=0x00FF, c=0x0080 → P=0x01FF. Then max: s=0xFFFF, c=0xFFFF → P=0x2FFFD, grouped as 2 beats → `out_data`=0x0301FC, `out_cnt`=2.
- Saturation: 200 beats of s=c=0xFFFF (P=0x2FFFD), last on beat 200 → `out_data`=0xFFFFFF, `out_sat`=1, `out_cnt`=200. The next group starts from acc=0 with sat clear.
- Back-pressure: hold `out_ready`=0 for 5 cycles with `out_valid`=1 while feeding `in_valid` continuously.
  - `in_ready`=0 throughout, outputs stable.
  - After release, the next groups emerge in order with correct sums and no lost beats.
- Simultaneous drain/reload: `out_ready`=1 on the same edge a new last product reaches stage 3 → `out_valid` stays 1 and `out_data` changes to the new group in one cycle.
- Reset mid-group: 3 beats accepted, assert `rst_n`=0 asynchronously between edges.
  - All outputs 0 immediately.
  - After release, a 1-beat group s=0x0001, c=0 gives `out_data`=1, `out_cnt`=1.
